silo_ro_mem_sched: RTL and testbench

Round-robin read scheduler that shares one read-only memory port between the three `silo_ro` subtype stages (0: tx_offset burst, 1: tx_data fetch, 2: spare/OL fetch). It registers the winning read request onto the AR channel and tracks outstanding bursts in an in-order FIFO. On the R channel it re-tags each data beat with its originating requester, CQ slot and word index, so responses can be turned into child tasks. It sits between the `silo_ro` stages and the tile's L2/memory read port.

---
 rtl/silo_ro_mem_sched.sv | 101 ++++++++++
 tb/tb_silo_ro_mem_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/silo_ro_mem_sched.sv
// silo_ro_mem_sched: round-robin AR scheduler with in-order burst tracker and R-beat re-tagging
module silo_ro_mem_sched #(
  parameter int N_REQ = 3,
  parameter int TRK_DEPTH = 8,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int AW = $clog2(TRK_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0][31:0]    req_addr,
  input  logic [N_REQ-1:0][7:0]     req_len,
  input  logic [N_REQ-1:0][7:0]     req_slot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [31:0]               m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [31:0]               m_rdata,
  input  logic                      m_rlast,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_data,
  output logic [PW-1:0]             resp_req_id,
  output logic [7:0]                resp_slot,
  output logic [7:0]                resp_word_id,
  output logic                      resp_last,
  output logic [AW:0]               outstanding,
  output logic                      len_err
);
  logic [PW-1:0] rr_ptr, grant;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [7:0]    word_cnt;
  logic [PW-1:0] trk_id   [TRK_DEPTH];
  logic [7:0]    trk_slot [TRK_DEPTH];
  logic [7:0]    trk_len  [TRK_DEPTH];
  logic full, empty, cap, r_hs, pop;
  // Scan downward so the requester nearest rr_ptr overwrites the others.
  always_comb begin
    grant = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int k;
      k = int'(rr_ptr) + i;
      k = (k >= N_REQ) ? k - N_REQ : k;
      if (req_valid[k]) grant = PW'(k);
    end
  end
  assign full = cnt == (AW+1)'(TRK_DEPTH);
  assign empty = cnt == '0;
  assign cap = (!m_arvalid || m_arready) && !full && |req_valid;
  assign req_ready = cap ? N_REQ'(1) << grant : '0;
  assign r_hs = m_rvalid && resp_ready;
  assign pop = r_hs && m_rlast && !empty;
  assign m_arsize = 3'd2;
  assign m_rready = resp_ready;
  assign resp_valid = m_rvalid;
  assign resp_data = m_rdata;
  assign resp_last = m_rlast;
  assign resp_req_id = trk_id[rd_ptr];
  assign resp_slot = trk_slot[rd_ptr];
  assign resp_word_id = word_cnt;
  assign outstanding = cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_arvalid <= 1'b0;
      m_araddr <= '0;
      m_arlen <= '0;
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      word_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      if (cap) begin
        m_arvalid <= 1'b1;
        m_araddr <= req_addr[grant];
        m_arlen <= req_len[grant];
        rr_ptr <= (grant == PW'(N_REQ - 1)) ? '0 : grant + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (m_arready) begin
        m_arvalid <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(cap) - (AW+1)'(pop);
      if (r_hs) word_cnt <= m_rlast ? 8'd0 : word_cnt + 8'd1;
      if (m_rvalid && (empty || (m_rlast != (word_cnt == trk_len[rd_ptr])))) len_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (cap) begin
      trk_id[wr_ptr] <= grant;
      trk_slot[wr_ptr] <= req_slot[grant];
      trk_len[wr_ptr] <= req_len[grant];
    end
  end
endmodule

// File: tb/tb_silo_ro_mem_sched.sv
// tb_silo_ro_mem_sched: directed checks of arbitration, tracker limits, beat tagging and length errors
module tb_silo_ro_mem_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] req_valid, req_ready;
  logic [2:0][31:0] req_addr;
  logic [2:0][7:0] req_len, req_slot;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, resp_valid, resp_ready, resp_last, len_err;
  logic [31:0] m_araddr, m_rdata, resp_data;
  logic [7:0] m_arlen, resp_slot, resp_word_id;
  logic [2:0] m_arsize;
  logic [1:0] resp_req_id;
  logic [3:0] outstanding;
  int checks = 0, errors = 0;
  silo_ro_mem_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_slot(req_slot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_req_id(resp_req_id), .resp_slot(resp_slot),
    .resp_word_id(resp_word_id), .resp_last(resp_last), .outstanding(outstanding), .len_err(len_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int n);
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    resp_ready = 1'b1;
    repeat (n) step;
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    #1;
  endtask
  initial begin
    req_valid = '0;
    req_len = '0;
    for (int r = 0; r < 3; r++) begin
      req_addr[r] = 32'h1000 * (r + 1);
      req_slot[r] = 8'h20 + 8'(r);
    end
    m_arready = 1'b0;
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    m_rdata = '0;
    resp_ready = 1'b0;
    #2;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_len_err", len_err, 0);
    chk("arsize", m_arsize, 2);
    #5 rst = 1'b0;
    step;
    // round robin, all requesters valid
    req_valid = 3'b111;
    m_arready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_ready", req_ready, 32'(1 << (i % 3)));
      step;
      if (i == 5) req_valid = '0;
      chk("rr_addr", m_araddr, 32'h1000 * (i % 3 + 1));
    end
    step;
    chk("rr_arvalid_off", m_arvalid, 0);
    chk("rr_outstanding", outstanding, 6);
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_resp_id", resp_req_id, i % 3);
      chk("rr_resp_slot", resp_slot, 8'h20 + i % 3);
      step;
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    #1;
    chk("rr_drained", outstanding, 0);
    // single request
    req_addr[0] = 32'h100;
    req_slot[0] = 8'h11;
    req_valid = 3'b001;
    #1;
    chk("one_ready", req_ready, 3'b001);
    step;
    req_valid = '0;
    chk("one_arvalid", m_arvalid, 1);
    chk("one_araddr", m_araddr, 32'h100);
    chk("one_arlen", m_arlen, 0);
    chk("one_outstanding", outstanding, 1);
    step;
    chk("one_ar_done", m_arvalid, 0);
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    m_rdata = 32'hdead0001;
    #1;
    chk("one_resp_valid", resp_valid, 1);
    chk("one_resp_data", resp_data, 32'hdead0001);
    chk("one_resp_id", resp_req_id, 0);
    chk("one_resp_slot", resp_slot, 8'h11);
    chk("one_word", resp_word_id, 0);
    chk("one_last", resp_last, 1);
    step;
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    #1;
    chk("one_popped", outstanding, 0);
    // arready stall
    req_addr[0] = 32'h200;
    req_valid = 3'b001;
    m_arready = 1'b0;
    #1;
    chk("stall_first_ready", req_ready, 3'b001);
    step;
    req_addr[0] = 32'h300;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", req_ready, 0);
      chk("stall_araddr", m_araddr, 32'h200);
      chk("stall_arvalid", m_arvalid, 1);
      step;
    end
    m_arready = 1'b1;
    #1;
    chk("stall_resume_ready", req_ready, 3'b001);
    step;
    req_valid = '0;
    chk("stall_next_addr", m_araddr, 32'h300);
    step;
    chk("stall_outstanding", outstanding, 2);
    drain(2);
    chk("stall_drained", outstanding, 0);
    // tracker full
    req_valid = 3'b010;
    #1;
    repeat (8) step;
    chk("full_outstanding", outstanding, 8);
    chk("full_ready", req_ready, 0);
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    #1;
    chk("full_pop_cycle_ready", req_ready, 0);
    chk("full_pop_id", resp_req_id, 1);
    step;
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    #1;
    chk("full_after_pop_ready", req_ready, 3'b010);
    chk("full_after_pop_out", outstanding, 7);
    step;
    req_valid = '0;
    chk("full_refill", outstanding, 8);
    step;
    drain(8);
    chk("full_drained", outstanding, 0);
    chk("full_len_err", len_err, 0);
    // 9-beat burst with resp_ready toggling
    req_addr[2] = 32'h500;
    req_len[2] = 8'd8;
    req_slot[2] = 8'h55;
    req_valid = 3'b100;
    #1;
    chk("burst_ready", req_ready, 3'b100);
    step;
    req_valid = '0;
    chk("burst_arlen", m_arlen, 8);
    step;
    begin
      int w, c;
      w = 0;
      c = 0;
      while (w < 9 && c < 40) begin
        resp_ready = (c % 2 == 0);
        m_rvalid = 1'b1;
        m_rlast = (w == 8);
        m_rdata = 32'(w);
        #1;
        chk("burst_word", resp_word_id, w);
        chk("burst_last", resp_last, w == 8);
        chk("burst_id", resp_req_id, 2);
        step;
        if (resp_ready) w++;
        c++;
      end
      chk("burst_all_beats", w, 9);
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("burst_outstanding", outstanding, 0);
    chk("burst_len_err", len_err, 0);
    chk("burst_word_reset", resp_word_id, 0);
    // early rlast
    req_addr[0] = 32'h600;
    req_len[0] = 8'd3;
    req_valid = 3'b001;
    #1;
    step;
    req_valid = '0;
    step;
    for (int b = 0; b < 3; b++) begin
      m_rvalid = 1'b1;
      m_rlast = (b == 2);
      #1;
      chk("early_no_err_yet", len_err, 0);
      step;
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    #1;
    chk("early_len_err", len_err, 1);
    chk("early_popped", outstanding, 0);
    repeat (3) step;
    chk("early_sticky", len_err, 1);
    // async reset mid-burst
    req_valid = 3'b001;
    #1;
    step;
    req_valid = '0;
    m_arready = 1'b0;
    m_rvalid = 1'b1;
    step;
    m_rvalid = 1'b0;
    chk("mid_arvalid", m_arvalid, 1);
    chk("mid_outstanding", outstanding, 1);
    chk("mid_word", resp_word_id, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_len_err", len_err, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_arvalid", m_arvalid, 0);
    chk("mid_rst_word", resp_word_id, 0);
    #2 rst = 1'b0;
    step;
    m_rvalid = 1'b1;
    step;
    m_rvalid = 1'b0;
    #1;
    chk("stale_beat_err", len_err, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
